// File: rtl/pll_reset_seq.sv
// PLL reset/lock sequencer: pulses the PLL reset, qualifies lock and releases sys_reset after stable lock.
// Optional build macro PLL_RESET_SEQ_AUTORETRY_EN re-resets the PLL on lock timeout before declaring FAULT.
module pll_reset_seq #(
    parameter int unsigned PLL_RST_CYCLES      = 16,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 1000000,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024
`ifdef PLL_RESET_SEQ_AUTORETRY_EN
    , parameter int unsigned MAX_RETRY         = 3
`endif
) (
    input  logic       refclk,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic       force_relock,
    output logic       pll_rst,
    output logic       sys_reset,
    output logic       fault,
    output logic [7:0] lock_loss_cnt
);

    localparam int unsigned MAX_AB  = (PLL_RST_CYCLES > LOCK_TIMEOUT_CYCLES) ? PLL_RST_CYCLES
                                                                              : LOCK_TIMEOUT_CYCLES;
    localparam int unsigned CNT_MAX = (MAX_AB > LOCK_STABLE_CYCLES) ? MAX_AB : LOCK_STABLE_CYCLES;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_PLL_RST,
        S_WAIT_LOCK,
        S_STABLE,
        S_RUN,
        S_FAULT
    } state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             locked_meta, locked_s;
    logic             pll_rst_next, sys_reset_next, fault_next;
    logic             lock_loss_inc;

`ifdef PLL_RESET_SEQ_AUTORETRY_EN
    localparam int unsigned RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);

    logic [RETRY_W-1:0] retries, retries_next;

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) retries <= '0;
        else        retries <= retries_next;
    end
`endif

    // pll_locked is asynchronous to refclk: two flops before any decision uses it.
    // NOTE: sequential state always uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            locked_meta <= 1'b0;
            locked_s    <= 1'b0;
        end else begin
            locked_meta <= pll_locked;
            locked_s    <= locked_meta;
        end
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_PLL_RST;
            cnt       <= '0;
            pll_rst   <= 1'b1;
            sys_reset <= 1'b1;
            fault     <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            pll_rst   <= pll_rst_next;
            sys_reset <= sys_reset_next;
            fault     <= fault_next;
        end
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n)
            lock_loss_cnt <= 8'd0;
        else if (lock_loss_inc && lock_loss_cnt != 8'hFF)
            lock_loss_cnt <= lock_loss_cnt + 8'd1;
    end

    // Counts in RUN only; a simultaneous force_relock does not hide the loss.
    assign lock_loss_inc = (state == S_RUN) && !locked_s;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
`ifdef PLL_RESET_SEQ_AUTORETRY_EN
        retries_next = retries;
`endif
        unique case (state)
            S_PLL_RST: begin
                if (cnt == RST_LAST) begin
                    state_next = S_WAIT_LOCK;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            S_WAIT_LOCK: begin
                if (locked_s) begin
                    state_next = S_STABLE;
                    cnt_next   = '0;
                end else if (cnt == TIMEOUT_LAST) begin
                    cnt_next = '0;
`ifdef PLL_RESET_SEQ_AUTORETRY_EN
                    if (retries < RETRY_LIMIT) begin
                        retries_next = retries + RETRY_W'(1);
                        state_next   = S_PLL_RST;
                    end else begin
                        state_next = S_FAULT;
                    end
`else
                    state_next = S_FAULT;
`endif
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            S_STABLE: begin
                // Any drop restarts qualification, so short glitches never release sys_reset.
                if (!locked_s) begin
                    state_next = S_WAIT_LOCK;
                    cnt_next   = '0;
                end else if (cnt == STABLE_LAST) begin
                    state_next = S_RUN;
                    cnt_next   = '0;
`ifdef PLL_RESET_SEQ_AUTORETRY_EN
                    retries_next = '0;
`endif
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            S_RUN: begin
                if (!locked_s) begin
                    state_next = S_WAIT_LOCK;
                    cnt_next   = '0;
                end
            end
            S_FAULT: begin
                state_next = S_FAULT;
            end
            default: begin
                state_next = S_PLL_RST;
                cnt_next   = '0;
            end
        endcase

        if (force_relock) begin
            state_next = S_PLL_RST;
            cnt_next   = '0;
`ifdef PLL_RESET_SEQ_AUTORETRY_EN
            retries_next = '0;
`endif
        end

        pll_rst_next   = (state_next == S_PLL_RST) || (state_next == S_FAULT);
        sys_reset_next = (state_next != S_RUN);
        fault_next     = (state_next == S_FAULT);
    end

endmodule

// File: tb/tb_pll_reset_seq.sv
// Directed bench for pll_reset_seq with small timing parameters; expectations are hand-derived edge counts.
// Honours PLL_RESET_SEQ_AUTORETRY_EN for the lock-timeout scenario.
module tb_pll_reset_seq;

    logic       refclk;
    logic       rst_n;
    logic       pll_locked;
    logic       force_relock;
    logic       pll_rst;
    logic       sys_reset;
    logic       fault;
    logic [7:0] lock_loss_cnt;

    int checks   = 0;
    int failures = 0;

    pll_reset_seq #(
        .PLL_RST_CYCLES      (4),
        .LOCK_TIMEOUT_CYCLES (32),
        .LOCK_STABLE_CYCLES  (8)
`ifdef PLL_RESET_SEQ_AUTORETRY_EN
        , .MAX_RETRY         (2)
`endif
    ) dut (
        .refclk        (refclk),
        .rst_n         (rst_n),
        .pll_locked    (pll_locked),
        .force_relock  (force_relock),
        .pll_rst       (pll_rst),
        .sys_reset     (sys_reset),
        .fault         (fault),
        .lock_loss_cnt (lock_loss_cnt)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge refclk);
        #1;
    endtask

    int pulses;
    int fault_at;
    int first_rise;
    int second_rise;
    int timeouts;
    logic prev_rst;

    initial begin
        rst_n        = 1'b0;
        pll_locked   = 1'b0;
        force_relock = 1'b0;

        // Reset state
        step(3);
        check("reset_pll_rst", pll_rst, 1);
        check("reset_sys_reset", sys_reset, 1);
        check("reset_fault", fault, 0);
        check("reset_lock_loss_cnt", lock_loss_cnt, 0);

        // 1: PLL reset pulse lasts exactly 4 edges after release
        rst_n = 1'b1;
        step(3);
        check("t1_pll_rst_edge3", pll_rst, 1);
        step(1);
        check("t1_pll_rst_edge4", pll_rst, 0);
        check("t1_sys_reset", sys_reset, 1);
        check("t1_fault", fault, 0);

        // 2: lock raised 4 edges later; release 10 edges after first high sample
        step(4);
        pll_locked = 1'b1;
        step(10);
        check("t2_sys_reset_e9", sys_reset, 1);
        step(1);
        check("t2_sys_reset_e10", sys_reset, 0);
        check("t2_pll_rst", pll_rst, 0);

        // 4: lock loss in RUN
        pll_locked = 1'b0;
        step(2);
        check("t4_sys_reset_e1", sys_reset, 0);
        step(1);
        check("t4_sys_reset_e2", sys_reset, 1);
        check("t4_lock_loss_cnt", lock_loss_cnt, 1);
        check("t4_pll_rst", pll_rst, 0);

        // 3: glitch (5 high, 1 low, high) during qualification
        pll_locked = 1'b1;
        step(5);
        pll_locked = 1'b0;
        step(1);
        pll_locked = 1'b1;
        step(5);
        check("t3_no_release_at_10", sys_reset, 1);
        step(5);
        check("t3_sys_reset_e9", sys_reset, 1);
        step(1);
        check("t3_release_e10", sys_reset, 0);
        check("t3_lock_loss_cnt", lock_loss_cnt, 1);

        // 5: force_relock, then never lock
        force_relock = 1'b1;
        pll_locked   = 1'b0;
        step(1);
        force_relock = 1'b0;
        check("t5_relock_pll_rst", pll_rst, 1);
        check("t5_relock_sys_reset", sys_reset, 1);
        check("t5_relock_no_loss", lock_loss_cnt, 1);
        step(3);
        check("t5_pulse_e3", pll_rst, 1);
        step(1);
        check("t5_pulse_e4", pll_rst, 0);

        pulses      = 0;
        fault_at    = 0;
        first_rise  = 0;
        second_rise = 0;
        prev_rst    = pll_rst;
        for (int n = 1; n <= 200; n++) begin
            step(1);
            if (fault && fault_at == 0) fault_at = n;
            if (!prev_rst && pll_rst && !fault) begin
                pulses++;
                if (pulses == 1) first_rise = n;
                if (pulses == 2) second_rise = n;
            end
            prev_rst = pll_rst;
            if (fault) break;
        end
`ifdef PLL_RESET_SEQ_AUTORETRY_EN
        check("t5_retry_pulses", pulses, 2);
        check("t5_first_retry_edge", first_rise, 32);
        check("t5_second_retry_edge", second_rise, 68);
        check("t5_fault_edge", fault_at, 104);
`else
        check("t5_retry_pulses", pulses, 0);
        check("t5_fault_edge", fault_at, 32);
`endif
        check("t5_fault", fault, 1);
        check("t5_fault_pll_rst", pll_rst, 1);
        check("t5_fault_sys_reset", sys_reset, 1);
        step(5);
        check("t5_fault_holds", fault, 1);

        force_relock = 1'b1;
        step(1);
        force_relock = 1'b0;
        check("t5_clear_fault", fault, 0);
        check("t5_new_pulse_start", pll_rst, 1);
        step(3);
        check("t5_new_pulse_e3", pll_rst, 1);
        step(1);
        check("t5_new_pulse_e4", pll_rst, 0);

        // 6: 300 lock losses saturate the counter at 255
        timeouts = 0;
        for (int i = 0; i < 300; i++) begin
            int w;
            pll_locked = 1'b1;
            w = 0;
            while (sys_reset && w < 40) begin
                step(1);
                w++;
            end
            if (sys_reset) timeouts++;
            pll_locked = 1'b0;
            w = 0;
            while (!sys_reset && w < 10) begin
                step(1);
                w++;
            end
            if (!sys_reset) timeouts++;
            if (i == 200) check("t6_count_mid", lock_loss_cnt, 202);
        end
        check("t6_no_wait_timeouts", timeouts, 0);
        check("t6_saturated", lock_loss_cnt, 255);

        // Async reset mid-STABLE
        pll_locked = 1'b1;
        step(5);
        check("t6_in_stable", sys_reset, 1);
        check("t6_stable_pll_rst", pll_rst, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_pll_rst", pll_rst, 1);
        check("async_sys_reset", sys_reset, 1);
        check("async_fault", fault, 0);
        check("async_lock_loss_cnt", lock_loss_cnt, 0);
        step(2);
        rst_n = 1'b1;
        step(3);
        check("post_reset_pulse_e3", pll_rst, 1);
        step(1);
        check("post_reset_pulse_e4", pll_rst, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
